// File: rtl/io_ctrl_pkg.sv
// io_ctrl_pkg: shared I/O opcode encodings and sequencer state type
package io_ctrl_pkg;

    localparam logic [1:0] OPIO_NONE = 2'b00;
    localparam logic [1:0] OPIO_IN   = 2'b01;
    localparam logic [1:0] OPIO_OUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IN_WAIT = 2'b01,
        IN_DONE = 2'b10,
        HALTED  = 2'b11
    } io_state_e;

endpackage

// File: rtl/io_ctrl_btn_debounce.sv
// btn_debounce: synchronizes, debounces and edge-detects the enter button
module btn_debounce #(
    parameter int DEBOUNCE = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_db,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // press is registered alongside btn_db so it lands in the cycle btn_db first reads high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            btn_db <= 1'b0;
            press  <= 1'b0;
            cnt    <= '0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == btn_db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                btn_db <= s2;
                press  <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: sequences IN/OUT/HLT against switches, enter button and display register
module io_ctrl
    import io_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SW_W     = 16,
    parameter int DEBOUNCE = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        op_io,
    input  logic              hlt,
    input  logic [SW_W-1:0]   sw,
    input  logic              btn_enter,
    input  logic [DATA_W-1:0] reg_data,
    output logic              stall,
    output logic [DATA_W-1:0] in_data,
    output logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              waiting,
    output logic              halted
);

    io_state_e state;
    logic      btn_db;
    logic      press;
    logic      accept;

    btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_enter),
        .btn_db  (btn_db),
        .press   (press)
    );

    assign accept = press & btn_db;

    // combinational IDLE term keeps a single-cycle CPU from advancing on the decode cycle
    assign stall = (state == IDLE && (op_io == OPIO_IN || hlt))
                 || state == IN_WAIT || state == HALTED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_data   <= '0;
            in_valid  <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            waiting   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            in_valid  <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (hlt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (op_io == OPIO_IN) begin
                        state   <= IN_WAIT;
                        waiting <= 1'b1;
                    end else if (op_io == OPIO_OUT) begin
                        out_data  <= reg_data;
                        out_valid <= 1'b1;
                    end
                end
                IN_WAIT: begin
                    if (accept) begin
                        in_data  <= DATA_W'(sw);
                        in_valid <= 1'b1;
                        waiting  <= 1'b0;
                        state    <= IN_DONE;
                    end
                end
                IN_DONE: state <= IDLE;
                HALTED:  state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: vector table, directed corner sequences and random run against a reference model
module tb_io_ctrl;

    localparam int DW  = 32;
    localparam int SWW = 16;
    localparam int DB  = 4;

    localparam int M_IDLE = 0, M_WAIT = 1, M_DONE = 2, M_HALT = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     op_io = 2'b00;
    logic           hlt = 1'b0;
    logic [SWW-1:0] sw = '0;
    logic           btn_enter = 1'b0;
    logic [DW-1:0]  reg_data = '0;
    logic           stall;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic [DW-1:0]  out_data;
    logic           out_valid;
    logic           waiting;
    logic           halted;

    io_ctrl #(.DATA_W(DW), .SW_W(SWW), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_io     (op_io),
        .hlt       (hlt),
        .sw        (sw),
        .btn_enter (btn_enter),
        .reg_data  (reg_data),
        .stall     (stall),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .waiting   (waiting),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int iv_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sequencer rules plus a debouncer stated as "flip after DB
    // consecutive differing samples of the 2-cycle-delayed raw button".
    int            m_st;
    bit            m_db, m_press, m_iv, m_ov;
    int            m_edge, m_last;
    bit            raw_q[$];
    logic [DW-1:0] m_in_data, m_out_data;

    function automatic bit seen(input int n);
        return (n >= 3) ? raw_q[n-3] : 1'b0;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_db = 0; m_press = 0; m_iv = 0; m_ov = 0;
        m_edge = 0; m_last = -1000; raw_q.delete();
        m_in_data = '0; m_out_data = '0;
    endtask

    function automatic bit m_stall();
        return (m_st == M_IDLE && (op_io == 2'b01 || hlt)) || m_st == M_WAIT || m_st == M_HALT;
    endfunction

    task automatic model_edge();
        bit pr, flip;
        pr = m_press;
        m_edge++;
        raw_q.push_back(btn_enter);
        m_iv = 0; m_ov = 0;
        case (m_st)
            M_IDLE: if (hlt) m_st = M_HALT;
                    else if (op_io == 2'b01) m_st = M_WAIT;
                    else if (op_io == 2'b10) begin m_out_data = reg_data; m_ov = 1; end
            M_WAIT: if (pr) begin m_in_data = DW'(sw); m_iv = 1; m_st = M_DONE; end
            M_DONE: m_st = M_IDLE;
            default: m_st = M_HALT;
        endcase
        flip = (m_edge - m_last >= DB);
        for (int i = 0; i < DB; i++) if (seen(m_edge - i) == m_db) flip = 0;
        m_press = flip && !m_db;
        if (flip) begin m_db = !m_db; m_last = m_edge; end
    endtask

    task automatic cyc(input logic [1:0] op, input logic h, input logic [SWW-1:0] s,
                       input logic b, input logic [DW-1:0] rd);
        op_io = op; hlt = h; sw = s; btn_enter = b; reg_data = rd;
        #1 chk("stall", stall, m_stall());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("in_data", in_data, m_in_data);
        chk("in_valid", in_valid, m_iv);
        chk("out_data", out_data, m_out_data);
        chk("out_valid", out_valid, m_ov);
        chk("waiting", waiting, m_st == M_WAIT);
        chk("halted", halted, m_st == M_HALT);
        if (in_valid) iv_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; op_io = 0; hlt = 0; btn_enter = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic          h;
        logic          b;
        logic [DW-1:0] rd;
        logic          e_stall;
        logic          e_ov;
        logic          e_halt;
        logic [DW-1:0] e_od;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int base, lat, btn_left;
        logic b;
        tbl[0] = '{2'b10, 1'b0, 1'b0, 32'h2A, 1'b0, 1'b1, 1'b0, 32'h2A};
        tbl[1] = '{2'b00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h2A};
        tbl[2] = '{2'b10, 1'b0, 1'b0, 32'h55, 1'b0, 1'b1, 1'b0, 32'h55};
        tbl[3] = '{2'b10, 1'b0, 1'b0, 32'h77, 1'b0, 1'b1, 1'b0, 32'h77};
        tbl[4] = '{2'b00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h77};
        tbl[5] = '{2'b10, 1'b0, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h77};
        tbl[6] = '{2'b01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h77};
        tbl[7] = '{2'b01, 1'b1, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 32'h77};

        model_reset();
        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_in_valid", in_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);
        rst_n = 1;

        // OUT, back-to-back OUT, then HLT with ignored traffic
        for (int i = 0; i < 8; i++) begin
            op_io = tbl[i].op; hlt = tbl[i].h; btn_enter = tbl[i].b; reg_data = tbl[i].rd;
            #1 chk("tbl_stall", stall, tbl[i].e_stall);
            cyc(tbl[i].op, tbl[i].h, 16'h0, tbl[i].b, tbl[i].rd);
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            chk("tbl_out_data", out_data, tbl[i].e_od);
            chk("tbl_halted", halted, tbl[i].e_halt);
            chk("tbl_in_valid", in_valid, 0);
        end
        for (int i = 0; i < 16; i++) cyc(2'(i % 3), 0, 16'h1234, 1'((i / 3) % 2), 32'h1);
        chk("halt_no_in", iv_cnt, 0);
        chk("halt_sticky", halted, 1);
        do_reset();
        #1 chk("halt_cleared", halted, 0);

        // IN with a clean press: latency from rise to in_valid
        cyc(2'b01, 0, 16'h00A5, 0, 0);
        chk("in_waiting", waiting, 1);
        for (int i = 0; i < 4; i++) cyc(2'b01, 0, 16'h00A5, 0, 0);
        base = iv_cnt; lat = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc((lat < 0) ? 2'b01 : 2'b00, 0, 16'h00A5, 1, 0);
            if (in_valid && lat < 0) begin
                lat = i;
                chk("in_data_a5", in_data, 32'h0000_00A5);
            end
        end
        chk("in_latency", lat, 7);
        chk("in_once", iv_cnt - base, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);

        // bouncing button in IN_WAIT never completes the IN
        base = iv_cnt;
        for (int i = 0; i < 16; i++) cyc(2'b01, 0, 16'h0F0F, 1'((i / 2) % 2), 0);
        for (int i = 0; i < 10; i++) cyc(2'b01, 0, 16'h0F0F, 0, 0);
        chk("bounce_no_iv", iv_cnt - base, 0);
        chk("bounce_stall", stall, 1);
        for (int i = 0; i < 10; i++) cyc(in_valid ? 2'b00 : 2'b01, 0, 16'h0F0F, 1, 0);
        chk("bounce_exit", iv_cnt - base, 1);

        // held button across a second IN gives no completion until release and re-press
        base = iv_cnt;
        for (int i = 0; i < 10; i++) cyc(2'b01, 0, 16'hBEEF, 1, 0);
        chk("held_no_iv", iv_cnt - base, 0);
        for (int i = 0; i < 8; i++) cyc(2'b01, 0, 16'hBEEF, 0, 0);
        for (int i = 0; i < 10; i++) cyc((iv_cnt > base) ? 2'b00 : 2'b01, 0, 16'hBEEF, 1, 0);
        chk("repress_once", iv_cnt - base, 1);
        chk("repress_data", in_data, 32'h0000_BEEF);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);

        // asynchronous reset in IN_WAIT
        cyc(2'b01, 0, 16'h0003, 0, 32'h5);
        cyc(2'b10, 0, 16'h0003, 0, 32'h5);
        #2 rst_n = 0; op_io = 0;
        model_reset();
        #1;
        chk("arst_waiting", waiting, 0);
        chk("arst_stall", stall, 0);
        chk("arst_in_data", in_data, 0);
        chk("arst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1;
        base = iv_cnt;
        for (int i = 0; i < 6; i++) cyc(0, 0, 16'h0003, 0, 0);
        chk("arst_no_iv", iv_cnt - base, 0);

        // randomized traffic against the model
        b = 0; btn_left = 3;
        for (int i = 0; i < 900; i++) begin
            if (btn_left == 0) begin b = ~b; btn_left = $urandom_range(1, 14); end
            btn_left--;
            cyc(2'($urandom_range(0, 3)), ($urandom_range(0, 60) == 0), 16'($urandom),
                b, $urandom);
            if (m_st == M_HALT && $urandom_range(0, 4) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
